// File: rtl/instr_decode_stage.sv
// Computer12 instruction-decode stage: decodes opcode words, gathers trailing
// immediates, honours skip/flush, and presents a registered valid/ready bundle.
module instr_decode_stage #(
   parameter int WORD_W = 12,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              flush,
   input  logic              skip_next,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_conditional,
   output logic [4:0]        out_dest,
   output logic [4:0]        out_src,
   output logic [4:0]        out_alu_op,
   output logic [3:0]        out_alu_cond,
   output logic              out_read_dest,
   output logic              out_read_src,
   output logic              out_write_dest,
   output logic              out_has_imm,
   output logic [WORD_W-1:0] out_imm,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic [5:0]        out_mem_mode
);

   typedef enum logic [1:0] {ST_OPC = 2'd0, ST_IMM = 2'd1, ST_DROP_IMM = 2'd2} state_t;

   typedef struct packed {
      logic       conditional;
      logic [4:0] dest;
      logic [4:0] src;
      logic [4:0] alu_op;
      logic [3:0] alu_cond;
      logic       read_dest;
      logic       read_src;
      logic       write_dest;
      logic       has_imm;
      logic       mem_read;
      logic       mem_write;
   } dec_t;

   function automatic dec_t decode(input logic [11:0] i);
      dec_t d;
      logic arith_v;
      logic shift_v;
      d            = '0;
      d.read_src   = 1'b1;
      d.write_dest = 1'b1;
      arith_v      = 1'b0;
      shift_v      = 1'b0;
      if (i[10:9] != 2'b11) begin
         arith_v     = 1'b1;
         d.dest      = {1'b0, i[10], i[5:3]};
         d.src       = {1'b0, i[9], i[2:0]};
         d.alu_op    = {2'b00, i[8:6]};
         d.has_imm   = ({1'b0, i[9], i[2:0]} == 5'd7);
         d.read_dest = (i[8:6] != 3'd0);
      end else if (i[10:3] == 8'b1100_1101) begin
         d.dest = 5'd31;
         d.src  = 5'd31;
      end else if (i[10:7] == 4'b1100) begin
         shift_v  = 1'b1;
         d.dest   = {1'b0, i[3:0]};
         d.src    = {1'b0, i[3:0]};
         d.alu_op = {2'b01, i[6:4]};
      end else if (i[11:8] == 4'b0111) begin
         d.dest     = {1'b1, i[3:0]};
         d.src      = {3'b000, i[7:6]};
         d.read_src = (i[5:0] < 6'd10);
         d.mem_read = (i[5:0] >= 6'd10);
      end else if (i[11:8] == 4'b1111) begin
         d.dest       = {3'b000, i[7:6]};
         d.src        = {1'b1, i[3:0]};
         d.write_dest = (i[5:0] < 6'd10);
         d.mem_write  = (i[5:0] >= 6'd10);
      end else begin
         d.dest       = {1'b0, i[3:0]};
         d.src        = {1'b0, i[3:0]};
         d.alu_op     = {1'b1, i[11], i[6], i[5:4]};
         d.alu_cond   = i[3:0];
         d.write_dest = 1'b0;
      end
      d.conditional = i[11] & (arith_v | shift_v);
      return d;
   endfunction

   state_t state_r;
   state_t state_nxt_s;
   logic   skip_pending_r;
   logic   skip_nxt_s;
   logic   valid_nxt_s;
   logic   accept_s;
   logic   skip_eff_s;
   logic   load_bundle_s;
   logic   load_imm_s;
   dec_t   dec_s;

   assign dec_s      = decode(in_word[11:0]);
   assign in_ready   = ~flush & ((state_r != ST_OPC) | ~out_valid | out_ready);
   assign accept_s   = in_valid & in_ready;
   // A skip pulse arriving with the opcode itself applies to that opcode.
   assign skip_eff_s = skip_pending_r | skip_next;

   // Next-state, valid and skip bookkeeping.
   always_comb begin
      state_nxt_s   = state_r;
      skip_nxt_s    = skip_pending_r | skip_next;
      valid_nxt_s   = out_valid & ~out_ready;
      load_bundle_s = 1'b0;
      load_imm_s    = 1'b0;
      if (flush) begin
         state_nxt_s = ST_OPC;
         skip_nxt_s  = 1'b0;
         valid_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_OPC: begin
               if (accept_s) begin
                  if (skip_eff_s) begin
                     skip_nxt_s  = 1'b0;
                     state_nxt_s = dec_s.has_imm ? ST_DROP_IMM : ST_OPC;
                  end else begin
                     load_bundle_s = 1'b1;
                     valid_nxt_s   = ~dec_s.has_imm;
                     state_nxt_s   = dec_s.has_imm ? ST_IMM : ST_OPC;
                  end
               end else begin
                  state_nxt_s = ST_OPC;
               end
            end
            ST_IMM: begin
               if (accept_s) begin
                  load_imm_s  = 1'b1;
                  valid_nxt_s = 1'b1;
                  state_nxt_s = ST_OPC;
               end else begin
                  state_nxt_s = ST_IMM;
               end
            end
            ST_DROP_IMM: begin
               if (accept_s) begin
                  state_nxt_s = ST_OPC;
               end else begin
                  state_nxt_s = ST_DROP_IMM;
               end
            end
            default: begin
               state_nxt_s = ST_OPC;
            end
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_OPC;
         skip_pending_r <= 1'b0;
         out_valid      <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         skip_pending_r <= skip_nxt_s;
         out_valid      <= valid_nxt_s;
      end
   end

   // Decode bundle registers; only written on an accepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_addr        <= '0;
         out_conditional <= 1'b0;
         out_dest        <= 5'd0;
         out_src         <= 5'd0;
         out_alu_op      <= 5'd0;
         out_alu_cond    <= 4'd0;
         out_read_dest   <= 1'b0;
         out_read_src    <= 1'b0;
         out_write_dest  <= 1'b0;
         out_has_imm     <= 1'b0;
         out_imm         <= '0;
         out_mem_read    <= 1'b0;
         out_mem_write   <= 1'b0;
         out_mem_mode    <= 6'd0;
      end else if (load_bundle_s) begin
         out_addr        <= in_addr;
         out_conditional <= dec_s.conditional;
         out_dest        <= dec_s.dest;
         out_src         <= dec_s.src;
         out_alu_op      <= dec_s.alu_op;
         out_alu_cond    <= dec_s.alu_cond;
         out_read_dest   <= dec_s.read_dest;
         out_read_src    <= dec_s.read_src;
         out_write_dest  <= dec_s.write_dest;
         out_has_imm     <= dec_s.has_imm;
         out_imm         <= '0;
         out_mem_read    <= dec_s.mem_read;
         out_mem_write   <= dec_s.mem_write;
         out_mem_mode    <= in_word[5:0];
      end else if (load_imm_s) begin
         out_imm <= in_word;
      end
   end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed-vector bench for instr_decode_stage with a transaction-level reference
// model compared every cycle plus literal spot checks.
module tb_instr_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_word;
   logic [11:0] in_addr;
   logic        flush;
   logic        skip_next;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_addr;
   logic        out_conditional;
   logic [4:0]  out_dest;
   logic [4:0]  out_src;
   logic [4:0]  out_alu_op;
   logic [3:0]  out_alu_cond;
   logic        out_read_dest;
   logic        out_read_src;
   logic        out_write_dest;
   logic        out_has_imm;
   logic [11:0] out_imm;
   logic        out_mem_read;
   logic        out_mem_write;
   logic [5:0]  out_mem_mode;

   int checks = 0;
   int errors = 0;

   instr_decode_stage #(.WORD_W(12), .ADDR_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .in_addr(in_addr), .flush(flush), .skip_next(skip_next),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_conditional(out_conditional), .out_dest(out_dest), .out_src(out_src),
      .out_alu_op(out_alu_op), .out_alu_cond(out_alu_cond),
      .out_read_dest(out_read_dest), .out_read_src(out_read_src),
      .out_write_dest(out_write_dest), .out_has_imm(out_has_imm), .out_imm(out_imm),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_mode(out_mem_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] addr;
      logic        conditional;
      logic [4:0]  dest;
      logic [4:0]  src;
      logic [4:0]  alu_op;
      logic [3:0]  alu_cond;
      logic        read_dest;
      logic        read_src;
      logic        write_dest;
      logic        has_imm;
      logic [11:0] imm;
      logic        mem_read;
      logic        mem_write;
      logic [5:0]  mem_mode;
   } exp_t;

   typedef struct packed {
      logic valid;
      logic want_imm;
      logic drop_imm;
      logic skip;
      exp_t b;
   } mdl_t;

   mdl_t m;

   // Reference decode straight from the instruction-class table.
   function automatic exp_t ref_decode(input logic [11:0] i, input logic [11:0] a);
      exp_t e;
      int   low6;
      low6         = int'(i[5:0]);
      e            = '0;
      e.addr       = a;
      e.read_src   = 1'b1;
      e.write_dest = 1'b1;
      e.mem_mode   = i[5:0];
      casez (i)
         12'b?0??_????_????, 12'b?10?_????_????: begin
            e.dest        = 5'(int'(i[10]) * 8 + int'(i[5:3]));
            e.src         = 5'(int'(i[9]) * 8 + int'(i[2:0]));
            e.alu_op      = 5'(int'(i[8:6]));
            e.has_imm     = (e.src == 5'd7);
            e.read_dest   = (e.alu_op != 5'd0);
            e.conditional = i[11];
         end
         12'b?110_0110_1???: begin
            e.dest = 5'd31;
            e.src  = 5'd31;
         end
         12'b?110_0???_????: begin
            e.dest        = 5'(int'(i[3:0]));
            e.src         = e.dest;
            e.alu_op      = 5'(8 + int'(i[6:4]));
            e.conditional = i[11];
         end
         12'b0111_????_????: begin
            e.dest     = 5'(16 + int'(i[3:0]));
            e.src      = 5'(int'(i[7:6]));
            e.read_src = (low6 < 10);
            e.mem_read = (low6 >= 10);
         end
         12'b1111_????_????: begin
            e.dest       = 5'(int'(i[7:6]));
            e.src        = 5'(16 + int'(i[3:0]));
            e.write_dest = (low6 < 10);
            e.mem_write  = (low6 >= 10);
         end
         default: begin
            e.dest       = 5'(int'(i[3:0]));
            e.src        = e.dest;
            e.alu_op     = 5'(16 + int'(i[11]) * 8 + int'(i[6]) * 4 + int'(i[5:4]));
            e.alu_cond   = i[3:0];
            e.write_dest = 1'b0;
         end
      endcase
      return e;
   endfunction

   function automatic logic exp_ready(input mdl_t s);
      return !flush && (s.want_imm || s.drop_imm || !s.valid || out_ready);
   endfunction

   // One clock of the transaction model: what the stage must hold after this edge.
   function automatic mdl_t model_step(input mdl_t s);
      mdl_t n;
      exp_t d;
      n = s;
      if (flush) begin
         n.valid    = 1'b0;
         n.want_imm = 1'b0;
         n.drop_imm = 1'b0;
         n.skip     = 1'b0;
      end else begin
         if (s.valid && out_ready) n.valid = 1'b0;
         n.skip = s.skip || skip_next;
         if (in_valid && exp_ready(s)) begin
            if (s.want_imm) begin
               n.b.imm    = in_word;
               n.valid    = 1'b1;
               n.want_imm = 1'b0;
            end else if (s.drop_imm) begin
               n.drop_imm = 1'b0;
            end else begin
               d = ref_decode(in_word, in_addr);
               if (s.skip || skip_next) begin
                  n.skip     = 1'b0;
                  n.drop_imm = d.has_imm;
               end else begin
                  n.b        = d;
                  n.valid    = !d.has_imm;
                  n.want_imm = d.has_imm;
               end
            end
         end
      end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state follows the DUT clock and reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_step(m);
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_in_ready", in_ready, exp_ready(m));
         chk("m_out_valid", out_valid, m.valid);
         if (m.valid) begin
            chk("m_addr", out_addr, m.b.addr);
            chk("m_cond", out_conditional, m.b.conditional);
            chk("m_dest", out_dest, m.b.dest);
            chk("m_src", out_src, m.b.src);
            chk("m_alu_op", out_alu_op, m.b.alu_op);
            chk("m_alu_cond", out_alu_cond, m.b.alu_cond);
            chk("m_read_dest", out_read_dest, m.b.read_dest);
            chk("m_read_src", out_read_src, m.b.read_src);
            chk("m_write_dest", out_write_dest, m.b.write_dest);
            chk("m_has_imm", out_has_imm, m.b.has_imm);
            chk("m_imm", out_imm, m.b.imm);
            chk("m_mem_read", out_mem_read, m.b.mem_read);
            chk("m_mem_write", out_mem_write, m.b.mem_write);
            chk("m_mem_mode", out_mem_mode, m.b.mem_mode);
         end
      end
   end

   task automatic set_in(input logic v, input logic [11:0] w, input logic [11:0] a,
                         input logic r, input logic sk, input logic fl);
      in_valid  = v;
      in_word   = w;
      in_addr   = a;
      out_ready = r;
      skip_next = sk;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      set_in(1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
      tick();
   endtask

   exp_t pin;

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);

      // Pin the reference decode with hand-computed values.
      pin = ref_decode(12'h0C5, 12'h000);
      chk("pin_0C5_src", pin.src, 5'd5);
      chk("pin_0C5_op", pin.alu_op, 5'd3);
      pin = ref_decode(12'h70A, 12'h000);
      chk("pin_70A_dest", pin.dest, 5'h1A);
      chk("pin_70A_memrd", pin.mem_read, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_addr", out_addr, 12'h000);
      chk("rst_out_read_src", out_read_src, 1'b0);
      rst_n = 1'b1;

      // Arithmetic, no immediate; then its conditional form.
      set_in(1'b1, 12'h0C5, 12'h010, 1'b1, 1'b0, 1'b0);
      tick();
      chk("ar_valid", out_valid, 1'b1);
      chk("ar_dest", out_dest, 5'd0);
      chk("ar_src", out_src, 5'd5);
      chk("ar_op", out_alu_op, 5'd3);
      chk("ar_rd", out_read_dest, 1'b1);
      chk("ar_imm", out_has_imm, 1'b0);
      chk("ar_addr", out_addr, 12'h010);
      set_in(1'b1, 12'h8C5, 12'h011, 1'b1, 1'b0, 1'b0);
      tick();
      chk("arc_cond", out_conditional, 1'b1);
      chk("arc_src", out_src, 5'd5);
      chk("arc_addr", out_addr, 12'h011);
      idle();

      // Instruction with trailing immediate.
      set_in(1'b1, 12'h007, 12'h020, 1'b1, 1'b0, 1'b0);
      tick();
      chk("imm_wait_valid", out_valid, 1'b0);
      set_in(1'b1, 12'hABC, 12'h021, 1'b1, 1'b0, 1'b0);
      tick();
      chk("imm_valid", out_valid, 1'b1);
      chk("imm_has", out_has_imm, 1'b1);
      chk("imm_src", out_src, 5'd7);
      chk("imm_rd", out_read_dest, 1'b0);
      chk("imm_val", out_imm, 12'hABC);
      chk("imm_addr", out_addr, 12'h020);
      idle();

      // Back-pressure for five cycles, then a sustained stream.
      set_in(1'b1, 12'h0C5, 12'h030, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, 12'h0C5, 12'h031, 1'b0, 1'b0, 1'b0);
         #1;
         chk("bp_in_ready", in_ready, 1'b0);
         tick();
         chk("bp_addr", out_addr, 12'h030);
      end
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, 12'h0C5, 12'(12'h031 + k), 1'b1, 1'b0, 1'b0);
         tick();
         chk("stream_valid", out_valid, 1'b1);
         chk("stream_addr", out_addr, 12'(12'h031 + k));
      end
      idle();

      // Skip drops the opcode and its immediate.
      set_in(1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
      tick();
      set_in(1'b1, 12'h007, 12'h040, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 12'h123, 12'h041, 1'b1, 1'b0, 1'b0);
      tick();
      chk("skip_hidden", out_valid, 1'b0);
      set_in(1'b1, 12'h70A, 12'h042, 1'b1, 1'b0, 1'b0);
      tick();
      chk("skip_valid", out_valid, 1'b1);
      chk("skip_dest", out_dest, 5'h1A);
      chk("skip_memrd", out_mem_read, 1'b1);
      chk("skip_mode", out_mem_mode, 6'h0A);
      chk("skip_rs", out_read_src, 1'b0);
      chk("skip_addr", out_addr, 12'h042);
      idle();

      // Flush while waiting for an immediate.
      set_in(1'b1, 12'h007, 12'h050, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 12'h0C5, 12'h0FF, 1'b1, 1'b0, 1'b1);
      #1;
      chk("fl_in_ready", in_ready, 1'b0);
      tick();
      chk("fl_valid", out_valid, 1'b0);
      set_in(1'b1, 12'h0C5, 12'h051, 1'b1, 1'b0, 1'b0);
      tick();
      chk("fl_next_valid", out_valid, 1'b1);
      chk("fl_next_addr", out_addr, 12'h051);
      chk("fl_next_src", out_src, 5'd5);
      idle();

      // Double skip pulse absorbed; skip coinciding with an opcode; flush beats skip.
      set_in(1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      set_in(1'b1, 12'h0C5, 12'h080, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 12'h0C5, 12'h081, 1'b1, 1'b0, 1'b0);
      tick();
      chk("dskip_addr", out_addr, 12'h081);
      set_in(1'b1, 12'h0C5, 12'h090, 1'b1, 1'b1, 1'b0);
      tick();
      chk("cskip_valid", out_valid, 1'b0);
      set_in(1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b1);
      tick();
      set_in(1'b1, 12'hF3C, 12'h0A0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("fskip_valid", out_valid, 1'b1);
      chk("st_memwr", out_mem_write, 1'b1);
      idle();

      // Asynchronous reset with a bundle pending, then mid-immediate.
      set_in(1'b1, 12'h0C5, 12'h060, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_addr", out_addr, 12'h000);
      tick();
      rst_n = 1'b1;
      set_in(1'b1, 12'h007, 12'h070, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_imm_valid", out_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      set_in(1'b1, 12'h0C5, 12'h071, 1'b1, 1'b0, 1'b0);
      tick();
      chk("arst_opc_valid", out_valid, 1'b1);
      chk("arst_opc_addr", out_addr, 12'h071);
      chk("arst_opc_imm", out_has_imm, 1'b0);
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
